// File: rtl/key_search_scheduler_pkg.sv
// ksched_pkg: shared state encoding, default key geometry and a priority-encode helper
// for the RC4 key search scheduler.
package ksched_pkg;

    typedef enum logic [1:0] {IDLE, DISPATCH, FOUND, EXHAUSTED} ksched_state_e;

    localparam int          KEY_WIDTH_DEF = 24;
    localparam logic [23:0] KEY_MAX_DEF   = 24'h3FFFFF;

    function automatic int lowest_set(input logic [15:0] vec);
        int r = 0;
        for (int i = 15; i >= 0; i--) if (vec[i]) r = i;
        return r;
    endfunction

endpackage

// File: rtl/key_search_scheduler_if.sv
// key_search_scheduler_if: scheduler <-> cores/host bundle.
// KSCHED_PROGRESS_EN adds the keys_tested progress counter.
interface key_search_scheduler_if
    import ksched_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = KEY_WIDTH_DEF
);
    logic                           start;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
    logic [NUM_CORES-1:0]           core_start;
    logic [NUM_CORES-1:0]           core_done;
    logic [NUM_CORES-1:0]           core_success;
    logic                           stop_all;
    logic                           found;
    logic [KEY_WIDTH-1:0]           found_key;
    logic                           exhausted;
    logic                           busy;
`ifdef KSCHED_PROGRESS_EN
    logic [KEY_WIDTH:0]             keys_tested;

    modport master (
        input  start, core_done, core_success,
        output core_key, core_start, stop_all, found, found_key, exhausted, busy, keys_tested
    );
    modport slave (
        output start, core_done, core_success,
        input  core_key, core_start, stop_all, found, found_key, exhausted, busy, keys_tested
    );
`else
    modport master (
        input  start, core_done, core_success,
        output core_key, core_start, stop_all, found, found_key, exhausted, busy
    );
    modport slave (
        output start, core_done, core_success,
        input  core_key, core_start, stop_all, found, found_key, exhausted, busy
    );
`endif
endinterface

// File: rtl/key_search_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the search starts at the pointer and wraps.
module rr_arbiter
    import ksched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);
    logic [IW-1:0] ptr;
    logic [N-1:0]  upper, pick;

    // Prefer requests at or above the pointer; fall back to the wrapped set.
    assign upper     = req & ~((N'(1) << ptr) - N'(1));
    assign pick      = (|upper) ? upper : req;
    assign grant     = pick & (~pick + N'(1));
    assign grant_idx = IW'(lowest_set(16'(grant)));
    assign valid     = |req;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            ptr <= '0;
        else if (advance && valid)
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);

endmodule

// File: rtl/key_search_scheduler.sv
// key_search_scheduler: hands successive keys to idle decrypt cores, latches the first hit.
// Build option KSCHED_PROGRESS_EN adds the keys_tested progress counter.
module key_search_scheduler
    import ksched_pkg::*;
#(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = KEY_WIDTH_DEF,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(KEY_MAX_DEF)
) (
    input logic                    clk,
    input logic                    reset_n,
    key_search_scheduler_if.master bus
);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    ksched_state_e        state, state_nx;
    logic [KEY_WIDTH:0]   next_key;
    logic [KEY_WIDTH-1:0] key_q [NUM_CORES];
    logic [KEY_WIDTH-1:0] found_key;
    logic [NUM_CORES-1:0] core_busy, core_start, accepted, succ, grant;
    logic [IW-1:0]        grant_idx, win;
    logic                 valid, hit, more, dispatch, restart;

    // Dones from idle cores are spurious and never reach the result logic.
    assign accepted = bus.core_done & core_busy;
    assign succ     = accepted & bus.core_success;
    assign hit      = |succ;
    assign win      = IW'(lowest_set(16'(succ)));
    assign more     = next_key <= {1'b0, KEY_MAX};
    assign dispatch = (state == DISPATCH) && !hit && more && valid;
    assign restart  = (state != DISPATCH) && bus.start;

    // Only cores idle at the start of the cycle may be granted.
    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (~core_busy),
        .advance   (dispatch),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (valid)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx = restart               ? DISPATCH  :
                   (state != DISPATCH)   ? state     :
                   hit                   ? FOUND     :
                   (!more && ~|core_busy) ? EXHAUSTED : DISPATCH;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_key   <= '0;
            core_busy  <= '0;
            core_start <= '0;
            found_key  <= '0;
            for (int i = 0; i < NUM_CORES; i++) key_q[i] <= '0;
        end else begin
            core_start <= dispatch ? grant : '0;
            if (restart) begin
                next_key  <= '0;
                core_busy <= '0;
            end else if (state == DISPATCH) begin
                core_busy <= (core_busy & ~accepted) | (dispatch ? grant : '0);
                if (dispatch) begin
                    next_key         <= next_key + (KEY_WIDTH+1)'(1);
                    key_q[grant_idx] <= next_key[KEY_WIDTH-1:0];
                end
                if (hit) found_key <= key_q[win];
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_key
        assign bus.core_key[g*KEY_WIDTH +: KEY_WIDTH] = key_q[g];
    end

    assign bus.core_start = core_start;
    assign bus.found      = state == FOUND;
    assign bus.exhausted  = state == EXHAUSTED;
    assign bus.stop_all   = (state == FOUND) || (state == EXHAUSTED);
    assign bus.busy       = state == DISPATCH;
    assign bus.found_key  = found_key;

`ifdef KSCHED_PROGRESS_EN
    logic [KEY_WIDTH:0] keys_tested;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            keys_tested <= '0;
        else if (restart)
            keys_tested <= '0;
        else if (state == DISPATCH)
            keys_tested <= keys_tested + (KEY_WIDTH+1)'($countones(accepted & ~bus.core_success));

    assign bus.keys_tested = keys_tested;
`endif

endmodule

// File: tb/tb_key_search_scheduler.sv
// tb_key_search_scheduler: emulated decrypt cores plus a key-ledger model of the search outcome.
module tb_key_search_scheduler;

    localparam int          NC = 4;
    localparam int          KW = 24;
    localparam logic [KW-1:0] KM = 24'd7;
    localparam int          NK = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    key_search_scheduler_if #(.NUM_CORES(NC), .KEY_WIDTH(KW)) bus ();

    key_search_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(KM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // core emulation / ledger state
    logic [NC-1:0] tb_busy, done_drv, succ_drv;
    int            tb_key [NC];
    int            cnt [NC];
    int            issued [NK];
    logic [31:0]   succ_mask;
    int            lat_fixed, exp_next, fails, cyc, first_start;
    bit            sync_en, spur_en, stopped, hit_pending, found_seen, exh_seen;
    logic [KW-1:0] exp_found;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string p);
        check({p, "_core_key"}, 64'(|bus.core_key), 0);
        check({p, "_core_start"}, 64'(bus.core_start), 0);
        check({p, "_flags"}, {60'd0, bus.stop_all, bus.found, bus.exhausted, bus.busy}, 0);
        check({p, "_found_key"}, 64'(bus.found_key), 0);
`ifdef KSCHED_PROGRESS_EN
        check({p, "_keys_tested"}, 64'(bus.keys_tested), 0);
`endif
    endtask

    // One clock: observe DUT after the edge, update the ledger, then drive the cores' replies.
    task automatic tick();
        logic [NC-1:0] st, real_d;
        int held, need, w;
        @(posedge clk);
        #1;
        cyc++;
        st = bus.core_start;
        if (hit_pending) begin
            check("hit_found", 64'(bus.found), 1);
            check("hit_stop_all", 64'(bus.stop_all), 1);
            check("hit_found_key", 64'(bus.found_key), 64'(exp_found));
            hit_pending = 0;
            found_seen  = 1;
        end
        if (bus.exhausted && !exh_seen) begin
            exh_seen = 1;
            check("exh_cores_idle", 64'(tb_busy), 0);
        end
        if (found_seen || exh_seen) check("quiet_after_end", 64'(st), 0);
        else if (st != 0) begin
            check("one_start_per_cycle", 64'($countones(st)), 1);
            if (first_start < 0) first_start = cyc;
        end
        for (int i = 0; i < NC; i++) if (st[i]) check("start_only_idle", 64'(tb_busy[i]), 0);
        tb_busy &= ~done_drv;
        done_drv = '0;
        succ_drv = '0;
        if (!stopped) begin
            need = $countones(succ_mask[NK-1:0]);
            held = 0;
            for (int i = 0; i < NC; i++) if (tb_busy[i] && succ_mask[tb_key[i]]) held++;
            for (int i = 0; i < NC; i++) begin
                if (!tb_busy[i]) continue;
                if (sync_en && succ_mask[tb_key[i]]) begin
                    if (held == need) begin
                        done_drv[i] = 1'b1;
                        succ_drv[i] = 1'b1;
                    end
                end else if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        done_drv[i] = 1'b1;
                        succ_drv[i] = succ_mask[tb_key[i]];
                    end
                end
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (st[i]) begin
                tb_key[i] = int'(bus.core_key[i*KW +: KW]);
                check("key_in_order", 64'(tb_key[i]), 64'(exp_next));
                if (exp_next < NK) issued[exp_next]++;
                exp_next++;
                tb_busy[i] = 1'b1;
                cnt[i] = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 12));
            end else if (tb_busy[i]) begin
                check("key_held", 64'(bus.core_key[i*KW +: KW]), 64'(tb_key[i]));
            end
        end
        real_d = done_drv;
        fails += $countones(real_d & ~succ_drv);
        if (|(real_d & succ_drv)) begin
            for (int i = NC - 1; i >= 0; i--) if (real_d[i] && succ_drv[i]) exp_found = KW'(tb_key[i]);
            hit_pending = 1;
            stopped     = 1;
        end
        if (!stopped && spur_en && $urandom_range(0, 5) == 0) begin
            w = int'($urandom_range(0, NC - 1));
            if (!tb_busy[w]) begin
                done_drv[w] = 1'b1;
                succ_drv[w] = 1'($urandom_range(0, 1));
            end
        end
        bus.core_done    = done_drv;
        bus.core_success = succ_drv | (NC'($urandom) & ~done_drv);
    endtask

    task automatic init_model(input logic [31:0] mask, input int lat, input bit sy, input bit sp);
        tb_busy = '0; done_drv = '0; succ_drv = '0;
        for (int i = 0; i < NC; i++) begin tb_key[i] = 0; cnt[i] = 0; end
        for (int k = 0; k < NK; k++) issued[k] = 0;
        succ_mask = mask; lat_fixed = lat; sync_en = sy; spur_en = sp;
        exp_next = 0; fails = 0; cyc = 0; first_start = -1;
        stopped = 0; hit_pending = 0; found_seen = 0; exh_seen = 0;
        bus.core_done = '0;
        bus.core_success = '0;
    endtask

    task automatic run(input logic [31:0] mask, input int lat, input bit sy, input bit sp);
        int  n;
        bit  want_found;
        want_found = |mask[NK-1:0];
        init_model(mask, lat, sy, sp);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_busy", 64'(bus.busy), 1);
        check("restart_cleared", {61'd0, bus.found, bus.exhausted, bus.stop_all}, 0);
`ifdef KSCHED_PROGRESS_EN
        check("restart_keys_tested", 64'(bus.keys_tested), 0);
`endif
        n = 0;
        while (!found_seen && !exh_seen && n < 3000) begin
            tick();
            n++;
        end
        check("search_terminated", 64'(found_seen | exh_seen), 1);
        repeat (4) tick();
        check("first_start_latency", 64'(first_start), 2);
        check("end_found", 64'(bus.found), 64'(want_found));
        check("end_exhausted", 64'(bus.exhausted), 64'(!want_found));
        check("end_stop_all", 64'(bus.stop_all), 1);
        check("end_busy", 64'(bus.busy), 0);
        if (!want_found) begin
            check("keys_issued_total", 64'(exp_next), NK);
            for (int k = 0; k < NK; k++) check("key_issued_once", 64'(issued[k]), 1);
        end
`ifdef KSCHED_PROGRESS_EN
        check("keys_tested", 64'(bus.keys_tested), 64'(fails));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mask;
        int          t, n;
        bit          sy;
        bus.start = 1'b0;
        bus.core_done = '0;
        bus.core_success = '0;
        init_model('0, 10, 0, 0);
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        run(32'h0, 10, 0, 0);                 // fixed latency, no hit -> exhausted
        run(32'h1 << 5, 10, 0, 0);            // key 5 succeeds
        run((32'h1 << 4) | (32'h1 << 6), 10, 1, 0);  // two simultaneous hits

        init_model(32'h0, 0, 0, 0);           // abort mid-search with reset
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (exp_next < 4 && n < 200) begin tick(); n++; end
        check("reached_key3", 64'(exp_next), 4);
        #2 reset_n = 1'b0;
        #1 check_zero("abort");
        bus.core_done = '0;
        @(negedge clk);
        reset_n = 1'b1;
        run(32'h0, 0, 0, 1);

        for (int it = 0; it < 10; it++) begin
            t    = int'($urandom_range(0, NK + 3));
            mask = 32'h1 << t;
            sy   = ($urandom_range(0, 2) == 0);
            if (sy) mask |= 32'h1 << $urandom_range(0, NK - 1);
            run(mask, 0, sy, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
